// File: rtl/proc_bus_alu_unit_pkg.sv
// rtl/proc_bus_alu_unit_pkg.sv - shared width default and ALU opcodes for the datapath core
package proc_bus_alu_unit_pkg;

  localparam int W_DEFAULT = 16;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;

endpackage

// File: rtl/proc_bus_alu_unit_alu16.sv
// rtl/proc_bus_alu_unit_alu16.sv - combinational ALU, A on the left and bus value on the right
module alu16
  import proc_bus_alu_unit_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic [W-1:0] result
);

  logic [3:0] shamt;
  assign shamt = b[3:0];

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_OR:   result = a | b;
      OP_SLT:  result = {{(W-1){1'b0}}, (a < b)};
      OP_SLL:  result = a << shamt;
      OP_SRL:  result = a >> shamt;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/proc_bus_alu_unit.sv
// rtl/proc_bus_alu_unit.sv - bus mux, register-field decoders, ALU and the A/G registers
module proc_bus_alu_unit
  import proc_bus_alu_unit_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic [W-1:0] DIN,
  input  logic [W-1:0] R0,
  input  logic [W-1:0] R1,
  input  logic [W-1:0] R2,
  input  logic [W-1:0] R3,
  input  logic [W-1:0] R4,
  input  logic [W-1:0] R5,
  input  logic [W-1:0] R6,
  input  logic [W-1:0] R7,
  input  logic [2:0]   IRx,
  input  logic [2:0]   IRy,
  input  logic         DecEn,
  output logic [7:0]   Xreg,
  output logic [7:0]   Yreg,
  input  logic         DinOut,
  input  logic [7:0]   RegOut,
  input  logic         GOut,
  input  logic         AIn,
  input  logic         GIn,
  input  logic [2:0]   AluOp,
  output logic [W-1:0] BusWires,
  output logic [W-1:0] AluResult,
  output logic [W-1:0] A,
  output logic [W-1:0] G
);

  always_comb begin
    Xreg = 8'h00;
    Yreg = 8'h00;
    if (DecEn) begin
      Xreg = 8'h01 << IRx;
      Yreg = 8'h01 << IRy;
    end
  end

  // Priority chain: multi-hot selects are legal, the earliest source wins.
  always_comb begin
    BusWires = '0;
    if      (DinOut)    BusWires = DIN;
    else if (RegOut[0]) BusWires = R0;
    else if (RegOut[1]) BusWires = R1;
    else if (RegOut[2]) BusWires = R2;
    else if (RegOut[3]) BusWires = R3;
    else if (RegOut[4]) BusWires = R4;
    else if (RegOut[5]) BusWires = R5;
    else if (RegOut[6]) BusWires = R6;
    else if (RegOut[7]) BusWires = R7;
    else if (GOut)      BusWires = G;
  end

  alu16 #(.W(W)) u_alu (
    .a      (A),
    .b      (BusWires),
    .op     (AluOp),
    .result (AluResult)
  );

  // A simultaneous AIn/GIn load leaves G with the result computed from the old A.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      A <= '0;
      G <= '0;
    end else begin
      if (AIn) A <= BusWires;
      if (GIn) G <= AluResult;
    end
  end

endmodule

// File: tb/tb_proc_bus_alu_unit.sv
// tb/tb_proc_bus_alu_unit.sv - vector table, hand sequences and randomized model check
module tb_proc_bus_alu_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] DIN;
  logic [15:0] R0, R1, R2, R3, R4, R5, R6, R7;
  logic [2:0]  IRx, IRy;
  logic        DecEn;
  logic [7:0]  Xreg, Yreg;
  logic        DinOut;
  logic [7:0]  RegOut;
  logic        GOut, AIn, GIn;
  logic [2:0]  AluOp;
  logic [15:0] BusWires, AluResult, A, G;

  int vectors = 0;
  int miscompares = 0;

  always #5 Clock = ~Clock;

  proc_bus_alu_unit #(.W(16)) dut (
    .Clock(Clock), .Reset(Reset), .DIN(DIN),
    .R0(R0), .R1(R1), .R2(R2), .R3(R3), .R4(R4), .R5(R5), .R6(R6), .R7(R7),
    .IRx(IRx), .IRy(IRy), .DecEn(DecEn), .Xreg(Xreg), .Yreg(Yreg),
    .DinOut(DinOut), .RegOut(RegOut), .GOut(GOut), .AIn(AIn), .GIn(GIn),
    .AluOp(AluOp), .BusWires(BusWires), .AluResult(AluResult), .A(A), .G(G)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic [15:0] exp;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_alu(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    longint ua, ub, r;
    ua = a;
    ub = b;
    case (op)
      3'd0: r = (ua + ub) % 65536;
      3'd1: r = (ua + 65536 - ub) % 65536;
      3'd2: r = a | b;
      3'd3: r = (ua < ub) ? 1 : 0;
      3'd4: r = (ua * (64'd1 << (ub % 16))) % 65536;
      3'd5: r = ua / (64'd1 << (ub % 16));
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  function automatic logic [15:0] ref_bus();
    logic [15:0] src [10];
    logic        sel [10];
    src[0] = DIN; sel[0] = DinOut;
    src[1] = R0; src[2] = R1; src[3] = R2; src[4] = R3;
    src[5] = R4; src[6] = R5; src[7] = R6; src[8] = R7;
    for (int i = 0; i < 8; i++) sel[i+1] = RegOut[i];
    src[9] = G; sel[9] = GOut;
    for (int i = 0; i < 10; i++)
      if (sel[i]) return src[i];
    return 16'h0000;
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    DinOut = 0; RegOut = 8'h00; GOut = 0; AIn = 0; GIn = 0;
  endtask

  task automatic load_a(input logic [15:0] v);
    idle();
    DIN = v; DinOut = 1; AIn = 1;
    tick();
    idle();
  endtask

  task automatic load_g_from_a();
    idle();
    AluOp = 3'b000; GIn = 1;
    tick();
    idle();
  endtask

  logic [15:0] a_m, g_m, bus_m, res_m;

  initial begin
    tv[0]  = '{16'hFFFF, 16'h0002, 3'b000, 16'h0001};
    tv[1]  = '{16'h0001, 16'h0002, 3'b001, 16'hFFFF};
    tv[2]  = '{16'h0005, 16'h0003, 3'b011, 16'h0000};
    tv[3]  = '{16'h0005, 16'h0006, 3'b011, 16'h0001};
    tv[4]  = '{16'h0005, 16'h00F0, 3'b010, 16'h00F5};
    tv[5]  = '{16'h0005, 16'h0014, 3'b100, 16'h0050};
    tv[6]  = '{16'h8000, 16'h0001, 3'b101, 16'h4000};
    tv[7]  = '{16'h0005, 16'hFFF4, 3'b100, 16'h0050};
    tv[8]  = '{16'h8000, 16'h000F, 3'b101, 16'h0001};
    tv[9]  = '{16'h1234, 16'h5678, 3'b110, 16'h0000};
    tv[10] = '{16'h1234, 16'h5678, 3'b111, 16'h0000};
    tv[11] = '{16'h0005, 16'h0005, 3'b011, 16'h0000};

    Reset = 1; DIN = 0; IRx = 0; IRy = 0; DecEn = 0; AluOp = 0;
    {R0, R1, R2, R3, R4, R5, R6, R7} = '0;
    idle();
    tick(); tick();
    chk("reset_A", A, 16'h0000);
    chk("reset_G", G, 16'h0000);
    Reset = 0;

    IRx = 3; IRy = 7; DecEn = 1; #1;
    chk("dec_x", {8'h00, Xreg}, 16'h0008);
    chk("dec_y", {8'h00, Yreg}, 16'h0080);
    DecEn = 0; #1;
    chk("dec_x_off", {8'h00, Xreg}, 16'h0000);
    chk("dec_y_off", {8'h00, Yreg}, 16'h0000);
    DecEn = 1;
    for (int i = 0; i < 8; i++) begin
      IRx = i[2:0]; IRy = 3'(7 - i); #1;
      chk("dec_x_loop", {8'h00, Xreg}, 16'(1 << i));
      chk("dec_y_loop", {8'h00, Yreg}, 16'(1 << (7 - i)));
    end

    R2 = 16'h1234;
    load_a(16'hBEEF);
    load_g_from_a();
    chk("g_beef", G, 16'hBEEF);
    RegOut = 8'b0000_0100; #1;
    chk("mux_r2", BusWires, 16'h1234);
    DinOut = 1; DIN = 16'h00AA; #1;
    chk("mux_din_wins", BusWires, 16'h00AA);
    DinOut = 0; RegOut = 8'b1000_0100; GOut = 1; #1;
    chk("mux_r2_over_r7_g", BusWires, 16'h1234);
    RegOut = 8'h00; #1;
    chk("mux_g", BusWires, 16'hBEEF);
    GOut = 0; #1;
    chk("mux_none", BusWires, 16'h0000);

    for (int i = 0; i < 12; i++) begin
      load_a(tv[i].a);
      DIN = tv[i].b; DinOut = 1; AluOp = tv[i].op; GIn = 1; #1;
      chk("tv_alu_comb", AluResult, tv[i].exp);
      tick();
      idle();
      chk("tv_g", G, tv[i].exp);
    end

    load_a(16'h0042);
    chk("a_load", A, 16'h0042);
    DIN = 16'h9999; DinOut = 1; AIn = 0;
    tick();
    chk("a_hold", A, 16'h0042);
    idle();

    load_a(16'h2222);
    load_g_from_a();
    load_a(16'h1111);
    chk("pre_reset_A", A, 16'h1111);
    chk("pre_reset_G", G, 16'h2222);
    Reset = 1; DIN = 16'h5555; DinOut = 1; AIn = 1; GIn = 1;
    tick();
    chk("mid_reset_A", A, 16'h0000);
    chk("mid_reset_G", G, 16'h0000);
    Reset = 0;
    idle();

    a_m = A; g_m = G;
    for (int n = 0; n < 300; n++) begin
      {R0, R1} = {$urandom, $urandom};
      {R2, R3} = {$urandom, $urandom};
      {R4, R5} = {$urandom, $urandom};
      {R6, R7} = {$urandom, $urandom};
      DIN = 16'($urandom);
      DinOut = ($urandom_range(0, 3) == 0);
      RegOut = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      GOut = 1'($urandom);
      AluOp = 3'($urandom);
      AIn = 1'($urandom);
      GIn = 1'($urandom);
      IRx = 3'($urandom); IRy = 3'($urandom); DecEn = 1'($urandom);
      #1;
      bus_m = ref_bus();
      res_m = ref_alu(a_m, bus_m, AluOp);
      chk("rnd_bus", BusWires, bus_m);
      chk("rnd_alu", AluResult, res_m);
      chk("rnd_xreg", {8'h00, Xreg}, DecEn ? 16'(1 << IRx) : 16'h0000);
      if (GIn) g_m = res_m;
      if (AIn) a_m = bus_m;
      tick();
      chk("rnd_A", A, a_m);
      chk("rnd_G", G, g_m);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
